data_mem_arbiter: RTL

- Shares the single-ported data memory between two requesters:
  - port 0: the core load/store unit
  - port 1: the debug/DMA loader
- Fixed priority to the core, with a starvation guard for port 1.
- Per-port req/ack handshake; each request's payload is latched; alignment and range are checked before any memory access.
- Sits between the requesters and the data memory's read/write flag, address, value and read-out ports.

---
 rtl/data_mem_arb_pkg.sv | 19 +
 rtl/dm_prio_select.sv | 26 ++
 rtl/data_mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the two-port data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    // Word-aligned and inside the byte range 0 .. 4*mem_words-1.
    function automatic logic word_ok(input logic [31:0] addr, input int unsigned mem_words);
        logic [33:0] limit;
        limit = {2'b00, mem_words} << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dm_prio_select.sv
// Fixed-priority grant selection: core first, aux port once the core has
// been granted MAX_CONSEC times in a row while aux waited.
module dm_prio_select
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic       mreq0,
    input  logic       mreq1,
    input  logic [3:0] cons,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = PORT_CORE;
        if (mreq1 && ((cons == 4'(MAX_CONSEC)) || !mreq0)) begin
            grant_valid = 1'b1;
            grant_idx   = PORT_AUX;
        end else if (mreq0) begin
            grant_valid = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-ported data memory between the core LSU (port 0)
// and the debug/DMA loader (port 1); one latched transaction at a time.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_WORDS  = 32,
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read_flag,
    output logic              mem_write_flag,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_val,
    input  logic [DATA_W-1:0] mem_read_out
);

    state_t              state_q, state_d;
    logic [3:0]          cons_q, cons_d;
    logic                gnt_q, we_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ack0_q, ack1_q, err0_q, err1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    logic                mreq0, mreq1;
    logic                grant_valid, grant_idx;
    logic                latch_en;
    logic                in_access, valid;

    // A port is masked in its own ack cycle so it cannot be served twice.
    assign mreq0     = req0 & ~ack0_q;
    assign mreq1     = req1 & ~ack1_q;
    assign in_access = (state_q == ST_ACCESS);
    assign valid     = word_ok(addr_q, MEM_WORDS);

    dm_prio_select #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_prio (
        .mreq0       (mreq0),
        .mreq1       (mreq1),
        .cons        (cons_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d  = state_q;
        cons_d   = cons_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    latch_en = 1'b1;
                    state_d  = ST_ACCESS;
                    if (grant_idx == PORT_AUX) begin
                        cons_d = 4'd0;
                    end else if (mreq1 && (cons_q != 4'(MAX_CONSEC))) begin
                        cons_d = cons_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!req1) begin
            cons_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cons_q   <= 4'd0;
            gnt_q    <= PORT_CORE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            cons_q  <= cons_d;
            if (latch_en) begin
                gnt_q   <= grant_idx;
                we_q    <= (grant_idx == PORT_AUX) ? we1    : we0;
                addr_q  <= (grant_idx == PORT_AUX) ? addr1  : addr0;
                wdata_q <= (grant_idx == PORT_AUX) ? wdata1 : wdata0;
            end
            ack0_q <= in_access && (gnt_q == PORT_CORE);
            ack1_q <= in_access && (gnt_q == PORT_AUX);
            if (in_access) begin
                if (gnt_q == PORT_CORE) begin
                    err0_q <= !valid;
                    if (!we_q) rdata0_q <= valid ? mem_read_out : '0;
                end else begin
                    err1_q <= !valid;
                    if (!we_q) rdata1_q <= valid ? mem_read_out : '0;
                end
            end
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign err0           = err0_q;
    assign err1           = err1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign mem_read_flag  = in_access & valid & ~we_q;
    assign mem_write_flag = in_access & valid & we_q;
    assign mem_addr       = addr_q;
    assign mem_val        = wdata_q;

endmodule
